sad_accum: RTL and testbench

//  Downstream consumer of the sub_abs_sub datapath result stream. Accepts 8-bit

---
 rtl/sad_pkg.sv | 18 +
 rtl/sad_cnt.sv | 32 +++
 rtl/sad_accum.sv | 114 +++++++++++
 tb/tb_sad_accum.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the block-SAD accumulator.
// State encoding, default geometry and the sum-width helper live here.
package sad_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT    = 16;

  // Wide enough that CNT full-scale samples can never overflow the sum.
  function automatic int acc_width(input int data_w, input int cnt);
    return data_w + $clog2(cnt);
  endfunction

endpackage

// File: rtl/sad_cnt.sv
// Modulo-CNT sample counter with enable, synchronous clear and a last-sample flag.
// Reset is synchronous, active-low.
module sad_cnt
  import sad_pkg::*;
#(
  parameter int CNT = DEF_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic last
);

  localparam int W = $clog2(CNT);
  localparam logic [W-1:0] LAST_VAL = W'(CNT - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign last = (cnt_reg == LAST_VAL);

endmodule

// File: rtl/sad_accum.sv
// Sums CNT consecutive handshaked samples into a block SAD and holds it on a valid/ready port.
// Optional running-max output is enabled by defining SAD_MAX_EN.
module sad_accum
  import sad_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT    = DEF_CNT,
  parameter int ACC_W  = acc_width(DATA_W, CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum
`ifdef SAD_MAX_EN
  ,
  output logic [DATA_W-1:0] out_max
`endif
);

  state_t state_reg, state_next;

  logic             xfer;
  logic             last;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] sum_reg;
  logic [ACC_W-1:0] acc_next;

  assign xfer     = in_valid & in_ready;
  assign acc_next = acc_reg + {{(ACC_W - DATA_W){1'b0}}, in_data};

  // Counter wraps to zero on the closing transfer so the next block starts clean.
  sad_cnt #(
    .CNT(CNT)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (xfer),
    .clr (xfer & last),
    .last(last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACCUM: if (xfer && last) state_next = ST_HOLD;
      ST_HOLD:  if (out_ready)    state_next = ST_ACCUM;
      default:                    state_next = ST_ACCUM;
    endcase
  end

  // No overlap: input is closed for the whole time a result is pending.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      ST_ACCUM: in_ready  = 1'b1;
      ST_HOLD:  out_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
      sum_reg <= '0;
    end else if (xfer) begin
      if (last) begin
        sum_reg <= acc_next;
        acc_reg <= '0;
      end else begin
        acc_reg <= acc_next;
      end
    end
  end

  assign out_sum = sum_reg;

`ifdef SAD_MAX_EN
  logic [DATA_W-1:0] max_reg;
  logic [DATA_W-1:0] out_max_reg;
  logic [DATA_W-1:0] max_next;

  assign max_next = (in_data > max_reg) ? in_data : max_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_reg     <= '0;
      out_max_reg <= '0;
    end else if (xfer) begin
      if (last) begin
        out_max_reg <= max_next;
        max_reg     <= '0;
      end else begin
        max_reg <= max_next;
      end
    end
  end

  assign out_max = out_max_reg;
`endif

endmodule

// File: tb/tb_sad_accum.sv
// Directed bench for sad_accum: hand-computed block sums, latency, backpressure and reset.
// Define SAD_MAX_EN to also check out_max.
module tb_sad_accum;

  localparam int DATA_W = 8;
  localparam int CNT    = 16;
  localparam int ACC_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
`ifdef SAD_MAX_EN
  logic [DATA_W-1:0] out_max;
`endif

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sad_accum #(
    .DATA_W(DATA_W),
    .CNT   (CNT),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum)
`ifdef SAD_MAX_EN
    ,
    .out_max  (out_max)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until an edge accepts it (bounded).
  task automatic send(input logic [DATA_W-1:0] d);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_within_bound", 32'(guard < 50), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // 1: reset
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b1;
    tick();

    // 2: 16 x 77 back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < CNT - 1; i++) send(8'd77);
    check("t2_no_early_valid", 32'(out_valid), 32'd0);
    send(8'd77);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_sum",   32'(out_sum),   32'd1232);
    check("t2_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    check("t2_valid_pulse_end", 32'(out_valid), 32'd0);
    check("t2_in_ready_back",   32'(in_ready),  32'd1);

    // 3: 16 x 255, full scale
    for (int i = 0; i < CNT; i++) send(8'd255);
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_out_sum",   32'(out_sum),   32'd4080);
`ifdef SAD_MAX_EN
    check("t3_out_max",   32'(out_max),   32'd255);
`endif
    tick();
    check("t3_valid_end", 32'(out_valid), 32'd0);

    // 4: 1..16 with a gap after every sample; hold result for test 5
    out_ready = 1'b0;
    for (int i = 1; i <= CNT - 1; i++) begin
      send(8'(i));
      tick();
    end
    check("t4_no_early_valid", 32'(out_valid), 32'd0);
    send(8'd16);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_out_sum",   32'(out_sum),   32'd136);
`ifdef SAD_MAX_EN
    check("t4_out_max",   32'(out_max),   32'd16);
`endif

    // 5: backpressure with samples offered that must be ignored
    in_valid = 1'b1;
    in_data  = 8'd200;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_valid_held",   32'(out_valid), 32'd1);
      check("t5_sum_held",     32'(out_sum),   32'd136);
      check("t5_in_ready_low", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t5_release", 32'(out_valid), 32'd0);
    for (int i = 0; i < CNT; i++) send(8'd2);
    check("t5_next_valid", 32'(out_valid), 32'd1);
    check("t5_next_sum",   32'(out_sum),   32'd32);
    tick();

    // 6: reset mid-block discards partial sum
    for (int i = 0; i < 7; i++) send(8'd50);
    rst = 1'b0;
    tick();
    check("t6_rst_out_sum",  32'(out_sum),  32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < CNT - 1; i++) send(8'd1);
    check("t6_no_early_valid", 32'(out_valid), 32'd0);
    send(8'd1);
    check("t6_out_valid", 32'(out_valid), 32'd1);
    check("t6_out_sum",   32'(out_sum),   32'd16);
`ifdef SAD_MAX_EN
    check("t6_out_max",   32'(out_max),   32'd1);
`endif
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
